glue_logic_ws: RTL and testbench
================================

# glue_logic_ws

Parametrised, clocked successor to the combinational glue-logic address decoder. Sits between the CPU bus master and the memory map: ROM at the bottom, N_RAM equal RAM banks, video RAM (VRAM) at the top. Accepts one bus request at a time and drives registered, one-hot chip selects. Inserts a per-region number of wait states before a one-cycle `ready` pulse, and rejects writes to ROM with an error pulse.

## Interface
Parameters:
- ADDR_W, 20, address width in bits.
- N_RAM, 4, number of RAM banks; must be a power of two, ≥2.
- ROM_TOP, 20'h03FFF, last ROM address (inclusive); ROM spans 0..ROM_TOP.
- VR_BASE, 20'hF0000, first VRAM address; VRAM spans VR_BASE..all-ones.
- WS_W, 4, wait-state counter width.
- WS_ROM, 2, wait states for ROM accesses.
- WS_RAM, 0, wait states for RAM accesses.
- WS_VR, 1, wait states for VRAM accesses. All WS_* must be < 2^WS_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  access address; sampled with req.
- cs_rom  out  1  ROM chip select, registered.
- cs_ram  out  N_RAM  RAM bank selects, registered, one-hot or zero.
- cs_vr  out  1  VRAM chip select, registered.
- ready  out  1  one-cycle pulse: access complete.
- err  out  1  one-cycle pulse: access rejected (write to ROM).
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Decode, priority order:
  - addr ≤ ROM_TOP → ROM.
  - addr ≥ VR_BASE → VRAM.
  - otherwise RAM, bank index = addr[ADDR_W-1 : ADDR_W-log2(N_RAM)].
- At defaults this gives:
  - ROM 00000–03FFF.
  - RAM0 04000–3FFFF, RAM1 40000–7FFFF, RAM2 80000–BFFFF, RAM3 C0000–EFFFF.
  - VRAM F0000–FFFFF.
- At most one of cs_rom, cs_ram[*], cs_vr is high in any cycle.
- State machine (states IDLE, ACCESS, ERROR):
  - IDLE, req=0: stay; all outputs 0.
  - IDLE, req=1, we=1, region ROM: go to ERROR; no chip select asserted.
  - IDLE, req=1, otherwise: latch the decoded select, load counter with the region's WS_*, go to ACCESS.
  - ACCESS: latched select held high. Counter decrements each cycle while non-zero. ready=1 in the cycle the counter is 0. Next edge returns to IDLE and clears the select.
  - ERROR: err=1 and ready=0 for exactly one cycle, then IDLE.
- req, we and addr are ignored outside IDLE. Changing addr mid-access does not affect the latched select.
- Reset: every output is 0 after the reset edge, state = IDLE, counter = 0.
  - Reset asserted mid-ACCESS aborts the access.
  - No ready or err is produced for the aborted access.
- Reset has priority over req in the same cycle.

## Timing
- req sampled high at edge k (state IDLE).
- Normal access:
  - Select and busy are high from cycle k+1 through cycle k+1+WS inclusive, i.e. WS+1 cycles.
  - ready is high only in cycle k+1+WS.
  - State is IDLE at cycle k+2+WS; a new req can be sampled at that edge.
  - Minimum request spacing is WS+2 cycles.
- Latency from req to ready at defaults: ROM 3, RAM 1, VRAM 2 cycles.
- Error access: err and busy high in cycle k+1 only; IDLE at k+2.
- A req held high continuously produces back-to-back accesses at the minimum spacing.

## Test plan
- Reset then read sweep: read each of 00000, 03FFF, 04000, 3FFFF, 40000, 7FFFF, 80000, BFFFF, C0000, EFFFF, F0000, FFFFF.
  - Correct single select for each: cs_rom; cs_ram = 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000; cs_vr.
  - ready at 3, 3, then 1 (×8), then 2, 2 cycles after req.
- Wait-state count: ROM read at 00100 → cs_rom high exactly 3 cycles, ready only in the 3rd. VRAM read at F1234 → cs_vr high 2 cycles.
- ROM write: we=1, addr=02000 → err=1 for one cycle, ready=0, all selects 0, busy for one cycle. A ROM read immediately after is serviced normally.
- Requests while busy: start ROM read, then pulse req with addr=80000 during ACCESS. The pulse is ignored: no cs_ram activity, exactly one ready.
- Reset mid-access: start ROM read, assert reset in the 2nd cycle.
  - Next cycle all outputs are 0.
  - No ready follows.
  - A subsequent RAM read at 40000 completes normally with cs_ram=0010.
- Held req: req=1 constantly with addr=04000 → ready pulses every 2 cycles (WS_RAM=0) and cs_ram[0] toggles 1,0,1,0.

Source files
------------

// File: rtl/glue_logic_ws.sv
// Clocked memory-map decoder: registered one-hot chip selects for ROM / RAM banks / VRAM,
// per-region wait states before a one-cycle ready pulse, and an error pulse for ROM writes.
module glue_logic_ws #(
   parameter int                ADDR_W  = 20,
   parameter int                N_RAM   = 4,
   parameter logic [ADDR_W-1:0] ROM_TOP = 20'h03FFF,
   parameter logic [ADDR_W-1:0] VR_BASE = 20'hF0000,
   parameter int                WS_W    = 4,
   parameter int                WS_ROM  = 2,
   parameter int                WS_RAM  = 0,
   parameter int                WS_VR   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   output logic              cs_rom,
   output logic [N_RAM-1:0]  cs_ram,
   output logic              cs_vr,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   localparam int RB = $clog2(N_RAM);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ERROR  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WS_W-1:0]   cnt_q, cnt_d;
   logic              cs_rom_q, cs_rom_d;
   logic [N_RAM-1:0]  cs_ram_q, cs_ram_d;
   logic              cs_vr_q, cs_vr_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   logic              is_rom_s;
   logic              is_vr_s;
   logic [RB-1:0]     bank_s;
   logic [WS_W-1:0]   ws_s;

   // Address decode in priority order ROM > VRAM > RAM, plus the region's wait-state count
   always_comb begin
      is_rom_s = (addr <= ROM_TOP);
      is_vr_s  = (addr >= VR_BASE) && !is_rom_s;
      bank_s   = addr[ADDR_W-1 -: RB];
      if (is_rom_s) begin
         ws_s = WS_W'(WS_ROM);
      end else if (is_vr_s) begin
         ws_s = WS_W'(WS_VR);
      end else begin
         ws_s = WS_W'(WS_RAM);
      end
   end

   // Next-state and next-output logic; ready/err/busy are computed one cycle early so they leave flops
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cs_rom_d = cs_rom_q;
      cs_ram_d = cs_ram_q;
      cs_vr_d  = cs_vr_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (we && is_rom_s) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end else begin
                  state_d  = ACCESS;
                  cnt_d    = ws_s;
                  cs_rom_d = is_rom_s;
                  cs_vr_d  = is_vr_s;
                  if (is_rom_s || is_vr_s) begin
                     cs_ram_d = '0;
                  end else begin
                     cs_ram_d = N_RAM'(1) << bank_s;
                  end
                  ready_d = (ws_s == '0);
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - WS_W'(1);
               ready_d = (cnt_q == WS_W'(1));
            end else begin
               state_d  = IDLE;
               cs_rom_d = 1'b0;
               cs_ram_d = '0;
               cs_vr_d  = 1'b0;
            end
         end
         ERROR: begin
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            cs_rom_d = 1'b0;
            cs_ram_d = '0;
            cs_vr_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cs_rom_q <= 1'b0;
         cs_ram_q <= '0;
         cs_vr_q  <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cs_rom_q <= cs_rom_d;
         cs_ram_q <= cs_ram_d;
         cs_vr_q  <= cs_vr_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign cs_rom = cs_rom_q;
   assign cs_ram = cs_ram_q;
   assign cs_vr  = cs_vr_q;
   assign ready  = ready_q;
   assign err    = err_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_glue_logic_ws.sv
// Directed bench for glue_logic_ws at default parameters; every expected value is hand-derived
// from the memory map and wait-state timing. Outputs are sampled 1 time unit after each rising edge.
module tb_glue_logic_ws;

   logic        clk = 1'b0;
   logic        reset, req, we;
   logic [19:0] addr;
   logic        cs_rom, cs_vr, ready, err, busy;
   logic [3:0]  cs_ram;

   int total = 0;
   int bad   = 0;

   glue_logic_ws dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
      .cs_rom(cs_rom), .cs_ram(cs_ram), .cs_vr(cs_vr),
      .ready(ready), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // observation vector {cs_rom, cs_ram[3:0], cs_vr, ready, err, busy}
   function automatic logic [8:0] obs();
      return {cs_rom, cs_ram, cs_vr, ready, err, busy};
   endfunction

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; we = 1'b0; addr = 20'h00000;
      step(); step();
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL reset_state: got %b want %b", obs(), 9'b0);
      end
      // reset wins over a simultaneous request
      req = 1'b1; addr = 20'h04000;
      step();
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL reset_priority: got %b want %b", obs(), 9'b0);
      end
      reset = 1'b0; req = 1'b0;
      step();
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL reset_release: got %b want %b", obs(), 9'b0);
      end
   endtask

   task automatic test_read_sweep();
      logic [19:0] a_tab [12];
      logic [5:0]  s_tab [12];
      int          l_tab [12];
      logic [8:0]  exp_v;
      a_tab = '{20'h00000, 20'h03FFF, 20'h04000, 20'h3FFFF, 20'h40000, 20'h7FFFF,
                20'h80000, 20'hBFFFF, 20'hC0000, 20'hEFFFF, 20'hF0000, 20'hFFFFF};
      s_tab = '{6'b100000, 6'b100000, 6'b000010, 6'b000010, 6'b000100, 6'b000100,
                6'b001000, 6'b001000, 6'b010000, 6'b010000, 6'b000001, 6'b000001};
      l_tab = '{3, 3, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
      for (int i = 0; i < 12; i++) begin
         req = 1'b1; we = 1'b0; addr = a_tab[i];
         for (int n = 1; n <= l_tab[i] + 1; n++) begin
            step();
            if (n == 1) req = 1'b0;
            if (n <= l_tab[i]) exp_v = {s_tab[i], (n == l_tab[i]), 1'b0, 1'b1};
            else               exp_v = 9'b0;
            total++;
            if (obs() !== exp_v) begin
               bad++;
               $display("FAIL sweep addr=%h cycle=%0d: got %b want %b", a_tab[i], n, obs(), exp_v);
            end
         end
      end
   endtask

   task automatic test_wait_states();
      int sel_cnt, rdy_cnt, rdy_at;
      // ROM read at 00100
      sel_cnt = 0; rdy_cnt = 0; rdy_at = 0;
      req = 1'b1; we = 1'b0; addr = 20'h00100;
      for (int n = 1; n <= 6; n++) begin
         step();
         req = 1'b0;
         if (cs_rom) sel_cnt++;
         if (ready) begin rdy_cnt++; rdy_at = n; end
      end
      total++;
      if (sel_cnt != 3 || rdy_cnt != 1 || rdy_at != 3) begin
         bad++;
         $display("FAIL ws_rom: got sel=%0d rdy=%0d at=%0d want sel=3 rdy=1 at=3", sel_cnt, rdy_cnt, rdy_at);
      end
      // VRAM read at F1234
      sel_cnt = 0; rdy_cnt = 0; rdy_at = 0;
      req = 1'b1; addr = 20'hF1234;
      for (int n = 1; n <= 6; n++) begin
         step();
         req = 1'b0;
         if (cs_vr) sel_cnt++;
         if (ready) begin rdy_cnt++; rdy_at = n; end
      end
      total++;
      if (sel_cnt != 2 || rdy_cnt != 1 || rdy_at != 2) begin
         bad++;
         $display("FAIL ws_vram: got sel=%0d rdy=%0d at=%0d want sel=2 rdy=1 at=2", sel_cnt, rdy_cnt, rdy_at);
      end
   endtask

   task automatic test_rom_write();
      logic [8:0] exp_v;
      req = 1'b1; we = 1'b1; addr = 20'h02000;
      step();
      req = 1'b0; we = 1'b0;
      total++;
      if (obs() !== 9'b000000_011) begin
         bad++; $display("FAIL rom_write_err: got %b want %b", obs(), 9'b000000_011);
      end
      // back in IDLE; issue a ROM read right away
      req = 1'b1; addr = 20'h00000;
      step();
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL rom_write_idle: got %b want %b", obs(), 9'b0);
      end
      for (int n = 1; n <= 4; n++) begin
         step();
         req = 1'b0;
         if (n <= 3) exp_v = {6'b100000, (n == 3), 1'b0, 1'b1};
         else        exp_v = 9'b0;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL rom_read_after_err cycle=%0d: got %b want %b", n, obs(), exp_v);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int ram_seen, rdy_cnt;
      ram_seen = 0; rdy_cnt = 0;
      req = 1'b1; we = 1'b0; addr = 20'h00000;
      for (int n = 1; n <= 7; n++) begin
         step();
         if (n == 1) begin req = 1'b1; addr = 20'h80000; end
         else        req = 1'b0;
         if (cs_ram != 4'b0000) ram_seen++;
         if (ready) rdy_cnt++;
      end
      total++;
      if (ram_seen != 0 || rdy_cnt != 1) begin
         bad++; $display("FAIL busy_ignore: got ram=%0d rdy=%0d want ram=0 rdy=1", ram_seen, rdy_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int rdy_cnt;
      rdy_cnt = 0;
      req = 1'b1; we = 1'b0; addr = 20'h00000;
      step();
      req = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL reset_mid_clear: got %b want %b", obs(), 9'b0);
      end
      for (int n = 0; n < 4; n++) begin
         step();
         if (ready || busy) rdy_cnt++;
      end
      total++;
      if (rdy_cnt != 0) begin
         bad++; $display("FAIL reset_mid_no_ready: got %0d active cycles want 0", rdy_cnt);
      end
      req = 1'b1; addr = 20'h40000;
      step();
      req = 1'b0;
      total++;
      if (obs() !== 9'b000100_101) begin
         bad++; $display("FAIL reset_mid_ram: got %b want %b", obs(), 9'b000100_101);
      end
      step();
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL reset_mid_ram_end: got %b want %b", obs(), 9'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] exp_v;
      req = 1'b1; we = 1'b0; addr = 20'h04000;
      for (int n = 1; n <= 8; n++) begin
         step();
         exp_v = (n % 2 == 1) ? 9'b000010_101 : 9'b0;
         total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL back_to_back cycle=%0d: got %b want %b", n, obs(), exp_v);
         end
      end
      req = 1'b0;
      step(); step();
      total++;
      if (obs() !== 9'b0) begin
         bad++; $display("FAIL back_to_back_idle: got %b want %b", obs(), 9'b0);
      end
   endtask

   initial begin
      test_reset();
      test_read_sweep();
      test_wait_states();
      test_rom_write();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
